// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared definitions for the MEM pipeline stage. EX and WB pack and unpack the
//   stage bundle with the same offsets.
//   - MEM_BUS_W / DATA_W / FWD_W : bundle, sram read data and bypass bus widths
//   - bundle field offsets        : alu_result, dest, gr_we, res_from_mem,
//                                   wb_data_req_is_use
//   - mem_state_e                 : MEM-stage FSM state encoding
//   - pack_fwd()                  : builds the {gr_we, dest, value} bypass word
package mem_stage_pkg;

  localparam int MEM_BUS_W = 166;
  localparam int DATA_W    = 32;
  localparam int FWD_W     = 38;

  // Bundle field layout. The low 40 bits hold the fields that MEM uses.
  // The rest of the bundle passes through unchanged to WB.
  localparam int ALU_RESULT_LSB   = 0;
  localparam int ALU_RESULT_W     = 32;
  localparam int DEST_LSB         = 32;
  localparam int DEST_W           = 5;
  localparam int GR_WE_BIT        = 37;
  localparam int RES_FROM_MEM_BIT = 38;
  localparam int REQ_IS_USE_BIT   = 39;

  typedef logic [MEM_BUS_W-1:0] mem_bus_t;

  // EMPTY: nothing held; WAIT: bundle held, sram response outstanding;
  // FULL: bundle complete; DRAIN: flushed but a response is still owed.
  typedef enum logic [1:0] {
    MEM_EMPTY = 2'd0,
    MEM_WAIT  = 2'd1,
    MEM_FULL  = 2'd2,
    MEM_DRAIN = 2'd3
  } mem_state_e;

  function automatic logic [FWD_W-1:0] pack_fwd(
    input logic                    gr_we,
    input logic [DEST_W-1:0]       dest,
    input logic [ALU_RESULT_W-1:0] value
  );
    return {gr_we, dest, value};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if
//   Groups the EX->MEM handshake, the data_sram response, the MEM->WB
//   handshake and the hazard outputs of the MEM stage.
//   - slave  : the view the MEM stage uses (EX/sram/WB inputs, stage outputs)
//   - master : the view of the surrounding pipeline that drives the stage
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                 ex_mem_valid;
  mem_bus_t             ex_mem_data;
  logic                 ex_req_accepted;
  logic                 mem_allowin;
  logic                 data_sram_data_ok;
  logic [DATA_W-1:0]    data_sram_rdata;
  logic                 wb_allowin;
  logic                 flush;
  logic                 mem_wb_valid;
  mem_bus_t             mem_wb_data;
  logic [DATA_W-1:0]    mem_result;
  logic [FWD_W-1:0]     mem_fwd;
  logic                 mem_load_pending;

  modport slave (
    input  ex_mem_valid, ex_mem_data, ex_req_accepted,
    input  data_sram_data_ok, data_sram_rdata,
    input  wb_allowin, flush,
    output mem_allowin, mem_wb_valid, mem_wb_data, mem_result,
    output mem_fwd, mem_load_pending
  );

  modport master (
    output ex_mem_valid, ex_mem_data, ex_req_accepted,
    output data_sram_data_ok, data_sram_rdata,
    output wb_allowin, flush,
    input  mem_allowin, mem_wb_valid, mem_wb_data, mem_result,
    input  mem_fwd, mem_load_pending
  );

endinterface

// File: rtl/mem_stage.sv
// mem_stage
//   Memory-access pipeline stage between EX and WB. It latches the EX bundle,
//   tracks the single outstanding data_sram response, and buffers the read
//   data if WB stalls. It hands the bundle and the raw load word to WB.
//   It also drives the MEM-stage bypass bus and the load interlock.
//   Ports:
//     clk   - stage clock
//     reset - asynchronous, active-high reset
//     bus   - mem_stage_if.slave: EX handshake, sram response, WB handshake,
//             flush, bypass and interlock outputs
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);

  mem_state_e         state;
  mem_state_e         state_next;
  mem_bus_t           bundle_q;
  logic [DATA_W-1:0]  rdata_buf;

  logic ready_go;
  logic allowin;
  logic accept;
  logic consume;
  logic data_ok;
  mem_state_e launch_state;

  assign data_ok  = bus.data_sram_data_ok;
  assign ready_go = (state == MEM_FULL) || ((state == MEM_WAIT) && data_ok);
  assign allowin  = (state == MEM_EMPTY) || (ready_go && bus.wb_allowin);
  assign consume  = ready_go && bus.wb_allowin;

  // flush kills the EX bundle that is presented in the same cycle.
  assign accept = bus.ex_mem_valid && allowin && !bus.flush;

  // A bundle waits for a response only if its request was accepted in EX.
  assign launch_state = (bus.ex_mem_data[REQ_IS_USE_BIT] && bus.ex_req_accepted)
                        ? MEM_WAIT : MEM_FULL;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MEM_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Flush has priority over everything else. A flushed
  // request that still owes a response parks in DRAIN, so that the late
  // data_ok is absorbed and never reaches WB.
  always_comb begin
    state_next = state;
    if (bus.flush) begin
      unique case (state)
        MEM_WAIT:  state_next = data_ok ? MEM_EMPTY : MEM_DRAIN;
        MEM_DRAIN: state_next = data_ok ? MEM_EMPTY : MEM_DRAIN;
        default:   state_next = MEM_EMPTY;
      endcase
    end else begin
      unique case (state)
        MEM_EMPTY: begin
          if (accept) state_next = launch_state;
        end
        MEM_WAIT: begin
          if (consume)      state_next = accept ? launch_state : MEM_EMPTY;
          else if (data_ok) state_next = MEM_FULL;
        end
        MEM_FULL: begin
          if (consume) state_next = accept ? launch_state : MEM_EMPTY;
        end
        MEM_DRAIN: begin
          if (data_ok) state_next = MEM_EMPTY;
        end
        default: state_next = MEM_EMPTY;
      endcase
    end
  end

  // Bundle register. It loads only on an accepted EX handoff.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bundle_q <= '0;
    end else if (accept) begin
      bundle_q <= bus.ex_mem_data;
    end
  end

  // Read-data buffer. It is written only when the response arrives while WB
  // is stalled. When WB is ready, the response passes straight through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_buf <= '0;
    end else if ((state == MEM_WAIT) && data_ok && !bus.wb_allowin && !bus.flush) begin
      rdata_buf <= bus.data_sram_rdata;
    end
  end

  assign bus.mem_allowin  = allowin;
  assign bus.mem_wb_valid = ready_go;
  assign bus.mem_wb_data  = bundle_q;
  assign bus.mem_result   = (state == MEM_WAIT) ? bus.data_sram_rdata : rdata_buf;

  // A load whose data arrives this cycle goes to WB together with that data.
  // So ID only needs to interlock while the response is still missing.
  assign bus.mem_load_pending = (state == MEM_WAIT) && bundle_q[RES_FROM_MEM_BIT] && !data_ok;

  assign bus.mem_fwd = pack_fwd(
    bundle_q[GR_WE_BIT] && ((state == MEM_WAIT) || (state == MEM_FULL)),
    bundle_q[DEST_LSB +: DEST_W],
    bundle_q[ALU_RESULT_LSB +: ALU_RESULT_W]
  );

  // The sram returns one response per accepted request. So a response with
  // nothing outstanding means the pipeline has broken that protocol.
  mem_data_ok_protocol: assert property (
    @(posedge clk) disable iff (reset)
    data_ok |-> ((state == MEM_WAIT) || (state == MEM_DRAIN))
  );

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
//   Self-checking bench for mem_stage. Every bundle handed to EX that should
//   reach WB is pushed to a scoreboard queue together with its expected load
//   word. The entry is popped and compared when the stage presents it to WB.
//   Inputs change 1 ns after the rising edge. Outputs are sampled on the
//   falling edge.
module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct {
    mem_bus_t           bundle;
    logic [DATA_W-1:0]  result;
    logic               check_result;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  exp_t sb_q[$];

  mem_stage_if dut_if ();

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit, so that a broken design cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic mem_bus_t make_bundle(input logic is_load, input logic req,
                                           input logic we, input logic [4:0] dest,
                                           input logic [31:0] alu);
    mem_bus_t b;
    for (int i = 0; i < MEM_BUS_W; i++) b[i] = 1'($urandom_range(0, 1));
    b[ALU_RESULT_LSB +: 32] = alu;
    b[DEST_LSB +: 5]        = dest;
    b[GR_WE_BIT]            = we;
    b[RES_FROM_MEM_BIT]     = is_load;
    b[REQ_IS_USE_BIT]       = req;
    return b;
  endfunction

  task automatic drive_idle();
    dut_if.ex_mem_valid      = 1'b0;
    dut_if.ex_mem_data       = '0;
    dut_if.ex_req_accepted   = 1'b0;
    dut_if.data_sram_data_ok = 1'b0;
    dut_if.data_sram_rdata   = '0;
    dut_if.wb_allowin        = 1'b1;
    dut_if.flush             = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    #2;
    @(negedge clk);
    checks++;
    if (dut_if.mem_wb_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_valid: got %b expected 0", dut_if.mem_wb_valid);
    end
    checks++;
    if (dut_if.mem_wb_data !== '0) begin
      failures++; $display("[TB] FAIL reset_data: got %h expected 0", dut_if.mem_wb_data);
    end
    checks++;
    if (dut_if.mem_fwd !== '0 || dut_if.mem_load_pending !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_fwd: got fwd=%h pend=%b expected 0/0", dut_if.mem_fwd, dut_if.mem_load_pending);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_if.mem_allowin !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_allowin: got %b expected 1", dut_if.mem_allowin);
    end
    next_cycle();
  endtask

  task automatic test_alu_pass();
    mem_bus_t b;
    exp_t e;
    b = make_bundle(1'b0, 1'b0, 1'b1, 5'd7, 32'hA5A5_0001);
    dut_if.ex_mem_valid = 1'b1;
    dut_if.ex_mem_data  = b;
    sb_q.push_back('{bundle: b, result: '0, check_result: 1'b0});
    @(negedge clk);
    checks++;
    if (dut_if.mem_allowin !== 1'b1) begin
      failures++; $display("[TB] FAIL alu_allowin: got %b expected 1", dut_if.mem_allowin);
    end
    next_cycle();
    dut_if.ex_mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_if.mem_wb_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL alu_valid: got %b expected 1", dut_if.mem_wb_valid);
    end
    checks++;
    if (sb_q.size() == 0) begin
      failures++; $display("[TB] FAIL alu_sb: got empty queue expected entry");
    end else begin
      e = sb_q.pop_front();
      if (dut_if.mem_wb_data !== e.bundle) begin
        failures++; $display("[TB] FAIL alu_data: got %h expected %h", dut_if.mem_wb_data, e.bundle);
      end
    end
    checks++;
    if (dut_if.mem_fwd !== {1'b1, 5'd7, 32'hA5A5_0001}) begin
      failures++; $display("[TB] FAIL alu_fwd: got %h expected %h", dut_if.mem_fwd, {1'b1, 5'd7, 32'hA5A5_0001});
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (dut_if.mem_wb_valid !== 1'b0 || dut_if.mem_fwd[37] !== 1'b0) begin
      failures++; $display("[TB] FAIL alu_empty: got valid=%b we=%b expected 0/0", dut_if.mem_wb_valid, dut_if.mem_fwd[37]);
    end
    next_cycle();
  endtask

  task automatic test_load_fast();
    mem_bus_t b;
    exp_t e;
    b = make_bundle(1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_1000);
    dut_if.ex_mem_valid    = 1'b1;
    dut_if.ex_mem_data     = b;
    dut_if.ex_req_accepted = 1'b1;
    sb_q.push_back('{bundle: b, result: 32'hDEADBEEF, check_result: 1'b1});
    next_cycle();
    dut_if.ex_mem_valid      = 1'b0;
    dut_if.ex_req_accepted   = 1'b0;
    dut_if.data_sram_data_ok = 1'b1;
    dut_if.data_sram_rdata   = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (dut_if.mem_wb_valid !== 1'b1 || dut_if.mem_load_pending !== 1'b0) begin
      failures++; $display("[TB] FAIL ldfast_valid: got valid=%b pend=%b expected 1/0", dut_if.mem_wb_valid, dut_if.mem_load_pending);
    end
    checks++;
    if (sb_q.size() == 0) begin
      failures++; $display("[TB] FAIL ldfast_sb: got empty queue expected entry");
    end else begin
      e = sb_q.pop_front();
      if (dut_if.mem_wb_data !== e.bundle || dut_if.mem_result !== e.result) begin
        failures++; $display("[TB] FAIL ldfast_data: got result %h expected %h", dut_if.mem_result, e.result);
      end
    end
    next_cycle();
    dut_if.data_sram_data_ok = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_if.mem_wb_valid !== 1'b0 || dut_if.mem_allowin !== 1'b1) begin
      failures++; $display("[TB] FAIL ldfast_after: got valid=%b allowin=%b expected 0/1", dut_if.mem_wb_valid, dut_if.mem_allowin);
    end
    next_cycle();
  endtask

  task automatic test_load_slow();
    mem_bus_t b;
    exp_t e;
    b = make_bundle(1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_2004);
    dut_if.ex_mem_valid    = 1'b1;
    dut_if.ex_mem_data     = b;
    dut_if.ex_req_accepted = 1'b1;
    sb_q.push_back('{bundle: b, result: 32'hC0FF_EE11, check_result: 1'b1});
    next_cycle();
    dut_if.ex_mem_valid    = 1'b0;
    dut_if.ex_req_accepted = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (dut_if.mem_load_pending !== 1'b1 || dut_if.mem_allowin !== 1'b0 || dut_if.mem_wb_valid !== 1'b0) begin
        failures++; $display("[TB] FAIL ldslow_wait%0d: got pend=%b allowin=%b valid=%b expected 1/0/0", i, dut_if.mem_load_pending, dut_if.mem_allowin, dut_if.mem_wb_valid);
      end
      next_cycle();
    end
    dut_if.data_sram_data_ok = 1'b1;
    dut_if.data_sram_rdata   = 32'hC0FF_EE11;
    @(negedge clk);
    checks++;
    if (dut_if.mem_wb_valid !== 1'b1 || dut_if.mem_load_pending !== 1'b0) begin
      failures++; $display("[TB] FAIL ldslow_valid: got valid=%b pend=%b expected 1/0", dut_if.mem_wb_valid, dut_if.mem_load_pending);
    end
    checks++;
    if (sb_q.size() == 0) begin
      failures++; $display("[TB] FAIL ldslow_sb: got empty queue expected entry");
    end else begin
      e = sb_q.pop_front();
      if (dut_if.mem_wb_data !== e.bundle || dut_if.mem_result !== e.result) begin
        failures++; $display("[TB] FAIL ldslow_data: got result %h expected %h", dut_if.mem_result, e.result);
      end
    end
    next_cycle();
    dut_if.data_sram_data_ok = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_if.mem_wb_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL ldslow_single: got valid=%b expected 0", dut_if.mem_wb_valid);
    end
    next_cycle();
  endtask

  task automatic test_wb_stall();
    mem_bus_t b;
    exp_t e;
    b = make_bundle(1'b1, 1'b1, 1'b1, 5'd12, 32'h0000_3008);
    dut_if.ex_mem_valid    = 1'b1;
    dut_if.ex_mem_data     = b;
    dut_if.ex_req_accepted = 1'b1;
    sb_q.push_back('{bundle: b, result: 32'h1234_5678, check_result: 1'b1});
    next_cycle();
    dut_if.ex_mem_valid      = 1'b0;
    dut_if.ex_req_accepted   = 1'b0;
    dut_if.wb_allowin        = 1'b0;
    dut_if.data_sram_data_ok = 1'b1;
    dut_if.data_sram_rdata   = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (dut_if.mem_wb_valid !== 1'b1 || dut_if.mem_allowin !== 1'b0) begin
      failures++; $display("[TB] FAIL stall_dataok: got valid=%b allowin=%b expected 1/0", dut_if.mem_wb_valid, dut_if.mem_allowin);
    end
    next_cycle();
    dut_if.data_sram_data_ok = 1'b0;
    dut_if.data_sram_rdata   = 32'hFFFF_0000;
    @(negedge clk);
    checks++;
    if (dut_if.mem_wb_valid !== 1'b1 || dut_if.mem_result !== 32'h1234_5678 || dut_if.mem_allowin !== 1'b0) begin
      failures++; $display("[TB] FAIL stall_hold: got valid=%b result=%h allowin=%b expected 1/12345678/0", dut_if.mem_wb_valid, dut_if.mem_result, dut_if.mem_allowin);
    end
    next_cycle();
    dut_if.wb_allowin = 1'b1;
    @(negedge clk);
    checks++;
    if (dut_if.mem_wb_valid !== 1'b1 || dut_if.mem_allowin !== 1'b1) begin
      failures++; $display("[TB] FAIL stall_release: got valid=%b allowin=%b expected 1/1", dut_if.mem_wb_valid, dut_if.mem_allowin);
    end
    checks++;
    if (sb_q.size() == 0) begin
      failures++; $display("[TB] FAIL stall_sb: got empty queue expected entry");
    end else begin
      e = sb_q.pop_front();
      if (dut_if.mem_wb_data !== e.bundle || dut_if.mem_result !== e.result) begin
        failures++; $display("[TB] FAIL stall_data: got result %h expected %h", dut_if.mem_result, e.result);
      end
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (dut_if.mem_wb_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL stall_after: got valid=%b expected 0", dut_if.mem_wb_valid);
    end
    next_cycle();
  endtask

  task automatic test_flush_drain();
    dut_if.ex_mem_valid    = 1'b1;
    dut_if.ex_mem_data     = make_bundle(1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_4000);
    dut_if.ex_req_accepted = 1'b1;
    next_cycle();
    dut_if.ex_mem_valid    = 1'b0;
    dut_if.ex_req_accepted = 1'b0;
    dut_if.flush           = 1'b1;
    @(negedge clk);
    checks++;
    if (dut_if.mem_wb_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL flush_cycle: got valid=%b expected 0", dut_if.mem_wb_valid);
    end
    next_cycle();
    dut_if.flush        = 1'b0;
    dut_if.ex_mem_valid = 1'b1;
    dut_if.ex_mem_data  = make_bundle(1'b0, 1'b0, 1'b1, 5'd5, 32'h5555_5555);
    @(negedge clk);
    checks++;
    if (dut_if.mem_wb_valid !== 1'b0 || dut_if.mem_allowin !== 1'b0 ||
        dut_if.mem_load_pending !== 1'b0 || dut_if.mem_fwd[37] !== 1'b0) begin
      failures++; $display("[TB] FAIL drain_hold: got valid=%b allowin=%b pend=%b we=%b expected 0/0/0/0", dut_if.mem_wb_valid, dut_if.mem_allowin, dut_if.mem_load_pending, dut_if.mem_fwd[37]);
    end
    next_cycle();
    dut_if.data_sram_data_ok = 1'b1;
    dut_if.data_sram_rdata   = 32'hBAD0_BAD0;
    @(negedge clk);
    checks++;
    if (dut_if.mem_wb_valid !== 1'b0 || dut_if.mem_allowin !== 1'b0) begin
      failures++; $display("[TB] FAIL drain_dataok: got valid=%b allowin=%b expected 0/0", dut_if.mem_wb_valid, dut_if.mem_allowin);
    end
    next_cycle();
    dut_if.data_sram_data_ok = 1'b0;
    dut_if.ex_mem_valid      = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_if.mem_wb_valid !== 1'b0 || dut_if.mem_allowin !== 1'b1) begin
      failures++; $display("[TB] FAIL drain_exit: got valid=%b allowin=%b expected 0/1", dut_if.mem_wb_valid, dut_if.mem_allowin);
    end
    next_cycle();
  endtask

  task automatic test_flush_full();
    dut_if.ex_mem_valid = 1'b1;
    dut_if.ex_mem_data  = make_bundle(1'b0, 1'b0, 1'b1, 5'd6, 32'h6666_0000);
    next_cycle();
    dut_if.ex_mem_valid = 1'b0;
    dut_if.wb_allowin   = 1'b0;
    dut_if.flush        = 1'b1;
    @(negedge clk);
    checks++;
    if (dut_if.mem_wb_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL flushfull_pre: got valid=%b expected 1", dut_if.mem_wb_valid);
    end
    next_cycle();
    dut_if.flush      = 1'b0;
    dut_if.wb_allowin = 1'b1;
    @(negedge clk);
    checks++;
    if (dut_if.mem_wb_valid !== 1'b0 || dut_if.mem_allowin !== 1'b1) begin
      failures++; $display("[TB] FAIL flushfull_post: got valid=%b allowin=%b expected 0/1", dut_if.mem_wb_valid, dut_if.mem_allowin);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    mem_bus_t b;
    exp_t e;
    logic [31:0] load_word;
    load_word = 32'h0BAD_F00D;
    for (int i = 0; i <= 5; i++) begin
      dut_if.data_sram_data_ok = (i == 3);
      dut_if.data_sram_rdata   = (i == 3) ? load_word : 32'h0;
      if (i < 5) begin
        b = make_bundle(i == 2, i == 2, 1'b1, 5'(i + 16), 32'h1000_0000 + 32'(i));
        dut_if.ex_mem_valid    = 1'b1;
        dut_if.ex_mem_data     = b;
        dut_if.ex_req_accepted = (i == 2);
        sb_q.push_back('{bundle: b, result: load_word, check_result: (i == 2)});
      end else begin
        dut_if.ex_mem_valid    = 1'b0;
        dut_if.ex_req_accepted = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (dut_if.mem_allowin !== 1'b1) begin
        failures++; $display("[TB] FAIL b2b_allowin%0d: got %b expected 1", i, dut_if.mem_allowin);
      end
      if (i > 0) begin
        checks++;
        if (dut_if.mem_wb_valid !== 1'b1 || sb_q.size() == 0) begin
          failures++; $display("[TB] FAIL b2b_valid%0d: got valid=%b queued=%0d expected 1/>0", i, dut_if.mem_wb_valid, sb_q.size());
        end else begin
          e = sb_q.pop_front();
          if (dut_if.mem_wb_data !== e.bundle || (e.check_result && dut_if.mem_result !== e.result)) begin
            failures++; $display("[TB] FAIL b2b_data%0d: got result %h expected %h", i, dut_if.mem_result, e.result);
          end
        end
      end
      next_cycle();
    end
    drive_idle();
    @(negedge clk);
    checks++;
    if (dut_if.mem_wb_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL b2b_end: got valid=%b expected 0", dut_if.mem_wb_valid);
    end
    next_cycle();
  endtask

  task automatic test_reset_in_wait();
    exp_t e;
    mem_bus_t b;
    dut_if.ex_mem_valid    = 1'b1;
    dut_if.ex_mem_data     = make_bundle(1'b1, 1'b1, 1'b1, 5'd21, 32'h0000_7000);
    dut_if.ex_req_accepted = 1'b1;
    next_cycle();
    dut_if.ex_mem_valid    = 1'b0;
    dut_if.ex_req_accepted = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_if.mem_load_pending !== 1'b1) begin
      failures++; $display("[TB] FAIL rstwait_pre: got pend=%b expected 1", dut_if.mem_load_pending);
    end
    next_cycle();
    reset = 1'b1;
    #1;
    checks++;
    if (dut_if.mem_load_pending !== 1'b0 || dut_if.mem_wb_data !== '0 ||
        dut_if.mem_fwd !== '0 || dut_if.mem_wb_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL rstwait_async: got pend=%b valid=%b fwd=%h expected 0/0/0", dut_if.mem_load_pending, dut_if.mem_wb_valid, dut_if.mem_fwd);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_if.mem_allowin !== 1'b1 || dut_if.mem_wb_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL rstwait_empty: got allowin=%b valid=%b expected 1/0", dut_if.mem_allowin, dut_if.mem_wb_valid);
    end
    next_cycle();
    b = make_bundle(1'b0, 1'b0, 1'b0, 5'd22, 32'h7777_7777);
    dut_if.ex_mem_valid = 1'b1;
    dut_if.ex_mem_data  = b;
    sb_q.push_back('{bundle: b, result: '0, check_result: 1'b0});
    next_cycle();
    dut_if.ex_mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_if.mem_wb_valid !== 1'b1 || sb_q.size() == 0) begin
      failures++; $display("[TB] FAIL rstwait_resume: got valid=%b queued=%0d expected 1/>0", dut_if.mem_wb_valid, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      if (dut_if.mem_wb_data !== e.bundle) begin
        failures++; $display("[TB] FAIL rstwait_data: got %h expected %h", dut_if.mem_wb_data, e.bundle);
      end
    end
    next_cycle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive_idle();
    test_reset();
    test_alu_pass();
    test_load_fast();
    test_load_slow();
    test_wb_stall();
    test_flush_drain();
    test_flush_full();
    test_back_to_back();
    test_reset_in_wait();
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("[TB] FAIL sb_drained: got %0d entries expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
